// File: rtl/det_sched_pkg.sv
// ============================================================================
// Module  : det_sched_pkg
// Brief   : Shared types and helpers for the detector scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package det_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] Z_NONE = 2'b00;

  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/detector_scheduler_if.sv
// ============================================================================
// Module  : detector_scheduler_if
// Brief   : Request/response bus between host fabric and detector scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface detector_scheduler_if #(
  parameter int N_REQ  = 2,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int ID_W   = det_sched_pkg::id_width(N_REQ)
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*WORD_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    res_valid;
  logic [ID_W-1:0]         res_id;
  logic [CNT_W-1:0]        res_hits;
  logic [1:0]              res_z;
  logic                    res_ready;

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_hits, res_z
  );

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_hits, res_z
  );
endinterface

`default_nettype wire

// File: rtl/detector_scheduler_arbiter.sv
// ============================================================================
// Module  : det_rr_arbiter
// Brief   : Round-robin grant with pointer advanced past the served requester.
//           DET_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module det_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [N_REQ-1:0] i_req,
  input  wire logic             i_adv,
  input  wire logic [ID_W-1:0]  i_adv_id,
  output logic      [N_REQ-1:0] o_grant,
  output logic      [ID_W-1:0]  o_gidx
);

  logic [N_REQ-1:0] w_cand;

`ifdef DET_SCHED_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, i_adv, i_adv_id};
  assign w_cand   = i_req;
`else
  logic [ID_W-1:0]  r_ptr;
  logic [N_REQ-1:0] w_hi;

  // Requests at or above the pointer win first; otherwise wrap to the bottom.
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_hi[i] = i_req[i] && (ID_W'(i) >= r_ptr);
    end
  end

  assign w_cand = (|w_hi) ? w_hi : i_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (i_adv_id == ID_W'(N_REQ - 1)) ? '0 : i_adv_id + 1'b1;
    end
  end
`endif

  always_comb begin
    o_grant = '0;
    o_gidx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        o_grant = N_REQ'(1) << i;
        o_gidx  = ID_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/detector_scheduler.sv
// ============================================================================
// Module  : detector_scheduler
// Brief   : Time-shares one serial sequence detector among N_REQ requesters.
//           DET_SCHED_FIXED_PRIO_EN (in det_rr_arbiter) selects fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module detector_scheduler
  import det_sched_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int ID_W   = id_width(N_REQ)
) (
  input  wire logic       clk,
  input  wire logic       rst,
  detector_scheduler_if.slave bus,
  output logic            det_rst,
  output logic            det_x,
  input  wire logic [1:0] det_z
);

  localparam int              BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             r_state;
  logic [WORD_W-1:0]  r_shift;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_hits;
  logic [1:0]         r_z;
  logic [BIT_W-1:0]   r_bit;

  logic [N_REQ-1:0]   w_grant;
  logic [ID_W-1:0]    w_gidx;
  logic [WORD_W-1:0]  w_word;
  logic               w_accept;
  logic               w_adv;
  logic               w_sample;

  assign w_accept = !rst && (r_state == IDLE) && (|bus.req_valid);
  assign w_adv    = (r_state == RESP) && bus.res_ready;
  // z lags x by one cycle, so the first SHIFT cycle has nothing to sample yet.
  assign w_sample = ((r_state == SHIFT) && (r_bit != '0)) || (r_state == DRAIN);

  det_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (bus.req_valid),
    .i_adv    (w_adv),
    .i_adv_id (r_id),
    .o_grant  (w_grant),
    .o_gidx   (w_gidx)
  );

  always_comb begin
    w_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_word = bus.req_data[i*WORD_W +: WORD_W];
    end
  end

  assign bus.req_ready = w_accept ? w_grant : '0;
  assign bus.res_valid = (r_state == RESP);
  assign bus.res_id    = r_id;
  assign bus.res_hits  = r_hits;
  assign bus.res_z     = r_z;
  assign det_rst       = rst | (r_state == CLEAR);
  assign det_x         = (r_state == SHIFT) & r_shift[WORD_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_id    <= '0;
      r_hits  <= '0;
      r_z     <= Z_NONE;
      r_bit   <= '0;
    end else begin
      if (w_sample) begin
        r_z <= det_z;
        if ((det_z != Z_NONE) && (r_hits != CNT_MAX)) r_hits <= r_hits + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= w_word;
            r_id    <= w_gidx;
            r_hits  <= '0;
            r_z     <= Z_NONE;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_bit   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_shift <= r_shift << 1;
          if (r_bit == LAST_BIT) begin
            r_state <= DRAIN;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        DRAIN: r_state <= RESP;
        RESP: begin
          if (bus.res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_detector_scheduler.sv
// ============================================================================
// Module  : tb_detector_scheduler
// Brief   : Self-checking bench with a 101 detector model and reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_detector_scheduler;
  localparam int N    = 3;
  localparam int W    = 8;
  localparam int C    = 2;
  localparam int CMAX = 3;
  localparam int W2   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  detector_scheduler_if #(.N_REQ(N), .WORD_W(W),  .CNT_W(C)) bus ();
  detector_scheduler_if #(.N_REQ(2), .WORD_W(W2), .CNT_W(C)) bus2 ();

  logic       det_rst, det_x, det_rst2, det_x2;
  logic [1:0] det_z, det_z2;
  logic [2:0] hist, hist2;

  detector_scheduler #(.N_REQ(N), .WORD_W(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .bus(bus), .det_rst(det_rst), .det_x(det_x), .det_z(det_z));
  detector_scheduler #(.N_REQ(2), .WORD_W(W2), .CNT_W(C)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .det_rst(det_rst2), .det_x(det_x2), .det_z(det_z2));

  // Reference detectors: z=01 registered when the last three x bits are 101.
  always @(posedge clk) begin
    if (det_rst) begin hist <= 3'b000; det_z <= 2'b00; end
    else begin
      hist  <= {hist[1:0], det_x};
      det_z <= ({hist[1:0], det_x} == 3'b101) ? 2'b01 : 2'b00;
    end
  end
  always @(posedge clk) begin
    if (det_rst2) begin hist2 <= 3'b000; det_z2 <= 2'b00; end
    else begin
      hist2  <= {hist2[1:0], det_x2};
      det_z2 <= ({hist2[1:0], det_x2} == 3'b101) ? 2'b01 : 2'b00;
    end
  end

  int checks = 0;
  int errors = 0;
  int rr_ptr = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_hits(input logic [15:0] w, input int width);
    int h = 0;
    logic [2:0] s = 3'b000;
    for (int b = width - 1; b >= 0; b--) begin
      s = {s[1:0], w[b]};
      if (s == 3'b101 && h < CMAX) h++;
    end
    return h;
  endfunction

  function automatic logic [1:0] ref_z(input logic [15:0] w, input int width);
    logic [2:0] s = 3'b000;
    for (int b = width - 1; b >= 0; b--) s = {s[1:0], w[b]};
    return (s == 3'b101) ? 2'b01 : 2'b00;
  endfunction

  function automatic int pick(input logic [N-1:0] m);
`ifdef DET_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (m[i]) return i;
`else
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr_ptr + k) % N;
      if (m[j]) return j;
    end
`endif
    return -1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(output logic [N-1:0] rdy);
    rdy = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      rdy = bus.req_ready;
      if (rdy != '0) break;
      tick();
    end
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.res_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1; bus.req_data = '0; bus.res_ready = 1'b0;
    bus2.req_valid = '0; bus2.req_data = '0; bus2.res_ready = 1'b0;
    repeat (3) tick();
    #1;
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 000", bus.req_ready); end
    checks++; if (det_rst !== 1'b1) begin errors++; $display("FAIL reset_det_rst got %b exp 1", det_rst); end
    checks++; if (det_x !== 1'b0) begin errors++; $display("FAIL reset_det_x got %b exp 0", det_x); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", bus.res_valid); end
    checks++; if (bus.res_id !== '0 || bus.res_hits !== '0 || bus.res_z !== 2'b00) begin
      errors++; $display("FAIL reset_res_fields got id=%0d hits=%0d z=%b exp 0 0 00", bus.res_id, bus.res_hits, bus.res_z); end
    bus.req_valid = '0;
    rst = 1'b0;
    rr_ptr = 0;
    tick();
  endtask

  task automatic test_single(input logic [7:0] word);
    logic [N-1:0] rdy;
    bus.req_data[7:0] = word; bus.req_valid = 3'b001; bus.res_ready = 1'b1;
    wait_grant(rdy);
    checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL single_grant got %b exp 001", rdy); end
    tick();
    bus.req_valid = '0;
    checks++; if (det_rst !== 1'b1 || det_x !== 1'b0) begin
      errors++; $display("FAIL single_clear got det_rst=%b det_x=%b exp 1 0", det_rst, det_x); end
    for (int b = 0; b < W; b++) begin
      tick();
      checks++; if (det_x !== word[W-1-b] || det_rst !== 1'b0) begin
        errors++; $display("FAIL single_bit%0d got det_x=%b det_rst=%b exp %b 0", b, det_x, det_rst, word[W-1-b]); end
    end
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b exp 0", bus.res_valid); end
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_hits !== C'(ref_hits({8'h00, word}, W))
                  || bus.res_z !== ref_z({8'h00, word}, W)) begin
      errors++; $display("FAIL single_result word=%b got v=%b id=%0d hits=%0d z=%b exp 1 0 %0d %b", word, bus.res_valid,
                         bus.res_id, bus.res_hits, bus.res_z, ref_hits({8'h00, word}, W), ref_z({8'h00, word}, W)); end
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_release got %b exp 0", bus.res_valid); end
    rr_ptr = 1;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] rdy;
    logic [7:0]   d [N];
    logic [7:0]   word;
    int g, exp_g, t, prev;
    bit ok;
    prev = -1;
    for (int i = 0; i < N; i++) begin d[i] = 8'($urandom); bus.req_data[i*W +: W] = d[i]; end
    bus.req_valid = 3'b011; bus.res_ready = 1'b1;
    repeat (6) begin
      wait_grant(rdy);
      g = oh2i(rdy); exp_g = pick(3'b011); t = cyc;
      checks++; if (g !== exp_g) begin errors++; $display("FAIL b2b_grant got %0d exp %0d", g, exp_g); end
      if (prev >= 0) begin
        checks++; if (t - prev !== W + 4) begin errors++; $display("FAIL b2b_period got %0d exp %0d", t - prev, W + 4); end
      end
      prev = t;
      word = (g >= 0) ? d[g] : 8'h00;
      tick();
      if (g >= 0) begin d[g] = 8'($urandom); bus.req_data[g*W +: W] = d[g]; end
      wait_res(ok);
      checks++; if (!ok || bus.res_id !== 2'(g) || bus.res_hits !== C'(ref_hits({8'h00, word}, W))
                    || bus.res_z !== ref_z({8'h00, word}, W)) begin
        errors++; $display("FAIL b2b_result got v=%b id=%0d hits=%0d z=%b exp 1 %0d %0d %b", ok, bus.res_id,
                           bus.res_hits, bus.res_z, g, ref_hits({8'h00, word}, W), ref_z({8'h00, word}, W)); end
      if (g >= 0) rr_ptr = (g + 1) % N;
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_hold();
    logic [N-1:0] rdy;
    logic [7:0]   word;
    int eh;
    logic [1:0] ez;
    bit ok;
    word = 8'($urandom); eh = ref_hits({8'h00, word}, W); ez = ref_z({8'h00, word}, W);
    bus.req_data[7:0] = word; bus.req_valid = 3'b001; bus.res_ready = 1'b0;
    wait_grant(rdy);
    checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL hold_grant got %b exp 001", rdy); end
    tick();
    bus.req_valid = 3'b111;
    wait_res(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_res_timeout got 0 exp 1"); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_hits !== C'(eh)
                    || bus.res_z !== ez || bus.req_ready !== '0) begin
        errors++; $display("FAIL hold_cycle%0d got v=%b id=%0d hits=%0d z=%b rdy=%b exp 1 0 %0d %b 000", c,
                           bus.res_valid, bus.res_id, bus.res_hits, bus.res_z, bus.req_ready, eh, ez); end
      tick();
    end
    bus.res_ready = 1'b1; bus.req_valid = '0;
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", bus.res_valid); end
    rr_ptr = 1;
  endtask

  task automatic test_random();
    logic [N-1:0] rdy, m;
    logic [7:0]   d [N];
    int g, exp_g, dly;
    bit ok;
    for (int it = 0; it < 12; it++) begin
      m = N'($urandom_range(1, 7));
      for (int i = 0; i < N; i++) begin d[i] = 8'($urandom); bus.req_data[i*W +: W] = d[i]; end
      bus.req_valid = m; bus.res_ready = 1'b0;
      wait_grant(rdy);
      g = oh2i(rdy); exp_g = pick(m);
      checks++; if (g !== exp_g) begin errors++; $display("FAIL rand_grant mask=%b got %0d exp %0d", m, g, exp_g); end
      tick();
      bus.req_valid = '0;
      wait_res(ok);
      dly = $urandom_range(0, 3);
      repeat (dly) tick();
      if (g < 0) g = 0;
      checks++; if (!ok || bus.res_valid !== 1'b1 || bus.res_id !== 2'(g) || bus.res_hits !== C'(ref_hits({8'h00, d[g]}, W))
                    || bus.res_z !== ref_z({8'h00, d[g]}, W)) begin
        errors++; $display("FAIL rand_result word=%b got v=%b id=%0d hits=%0d z=%b exp 1 %0d %0d %b", d[g], bus.res_valid,
                           bus.res_id, bus.res_hits, bus.res_z, g, ref_hits({8'h00, d[g]}, W), ref_z({8'h00, d[g]}, W)); end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      rr_ptr = (g + 1) % N;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_saturate();
    logic [15:0] words [2];
    bit got_rdy, got_res;
    words[0] = 16'hAAAA; words[1] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      bus2.req_data[15:0] = words[k]; bus2.req_valid = 2'b01; bus2.res_ready = 1'b1;
      got_rdy = 1'b0; got_res = 1'b0;
      for (int c = 0; c < 40 && !got_rdy; c++) begin
        #1;
        if (bus2.req_ready == 2'b01) got_rdy = 1'b1;
        tick();
      end
      bus2.req_valid = '0;
      for (int c = 0; c < 60 && !got_res; c++) begin
        if (bus2.res_valid === 1'b1) got_res = 1'b1;
        else tick();
      end
      checks++; if (!got_rdy || !got_res || bus2.res_hits !== C'(ref_hits(words[k], W2))
                    || bus2.res_z !== ref_z(words[k], W2)) begin
        errors++; $display("FAIL sat_result word=%h got rdy=%b v=%b hits=%0d z=%b exp 1 1 %0d %b", words[k], got_rdy,
                           got_res, bus2.res_hits, bus2.res_z, ref_hits(words[k], W2), ref_z(words[k], W2)); end
      tick();
    end
  endtask

  task automatic test_abort();
    logic [N-1:0] rdy;
    bit bad;
    bus.req_data[7:0] = 8'($urandom); bus.req_valid = 3'b001; bus.res_ready = 1'b1;
    wait_grant(rdy);
    checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL abort_grant got %b exp 001", rdy); end
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++; if (det_rst !== 1'b1) begin errors++; $display("FAIL abort_det_rst got %b exp 1", det_rst); end
    tick();
    rst = 1'b0;
    rr_ptr = 0;
    #1;
    checks++; if (det_rst !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle got det_rst=%b v=%b exp 0 0", det_rst, bus.res_valid); end
    bad = 1'b0;
    repeat (15) begin
      if (bus.res_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL abort_no_result got 1 exp 0"); end
    test_single(8'b0110_1101);
  endtask

  initial begin
    test_reset();
    test_single(8'b1011_0010);
    test_single(8'b1010_1010);
    test_single(8'b1111_1111);
    test_back_to_back();
    test_hold();
    test_random();
    test_saturate();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
